axis_iter_div: RTL and testbench

Iterative radix-2 restoring divider that acts as the responder on the AXI-stream divide interface driven by the core's divide-issue logic in the EXE stage. It drop-in replaces the vendor divider IP cores (signed and unsigned instances), with the same port set and the same 64-bit result packing. One operation is in flight at a time. The result is presented as a single-cycle, non-backpressured valid pulse.

---
 rtl/axis_iter_div.sv | 115 +++++++++++
 tb/tb_axis_iter_div.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/axis_iter_div.sv
// Iterative radix-2 restoring divider on an AXI-stream operand/result interface.
// One operation in flight; the result appears as a one-cycle, non-backpressured pulse.
module axis_iter_div #(
    parameter bit SIGNED = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] s_axis_dividend_tdata,
    input  logic        s_axis_dividend_tvalid,
    output logic        s_axis_dividend_tready,
    input  logic [31:0] s_axis_divisor_tdata,
    input  logic        s_axis_divisor_tvalid,
    output logic        s_axis_divisor_tready,
    output logic [63:0] m_axis_dout_tdata,
    output logic        m_axis_dout_tvalid
);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t      state_reg, state_next;
    logic        load_en, iter_en, write_en;
    logic [4:0]  cnt_reg;
    logic [32:0] rem_reg;
    logic [31:0] quo_reg, dsr_reg, dvd_reg;
    logic        q_sign_reg, r_sign_reg, dz_reg;
    logic [63:0] dout_reg;
    logic        dout_valid_reg;

    logic        dvd_neg, dsr_neg;
    logic [31:0] dvd_mag, dsr_mag;
    logic [33:0] trial;
    logic        q_bit;
    logic [32:0] rem_next;
    logic [31:0] q_fix, r_fix;

    // Magnitudes on 32 bits: |0x80000000| stays 0x80000000, which the unsigned core handles.
    assign dvd_neg = SIGNED && s_axis_dividend_tdata[31];
    assign dsr_neg = SIGNED && s_axis_divisor_tdata[31];
    assign dvd_mag = dvd_neg ? (32'd0 - s_axis_dividend_tdata) : s_axis_dividend_tdata;
    assign dsr_mag = dsr_neg ? (32'd0 - s_axis_divisor_tdata) : s_axis_divisor_tdata;

    // Partial remainder stays below the divisor, so its top bit is zero before each shift.
    assign trial    = {rem_reg, quo_reg[31]} - {2'b00, dsr_reg};
    assign q_bit    = ~trial[33];
    assign rem_next = q_bit ? trial[32:0] : {rem_reg[31:0], quo_reg[31]};

    assign q_fix = q_sign_reg ? (32'd0 - quo_reg) : quo_reg;
    assign r_fix = r_sign_reg ? (32'd0 - rem_reg[31:0]) : rem_reg[31:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (load_en) state_next = CALC;
            CALC:    if (cnt_reg == 5'd31) state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        load_en  = (state_reg == IDLE) && s_axis_dividend_tvalid && s_axis_divisor_tvalid;
        iter_en  = (state_reg == CALC);
        write_en = (state_reg == FIX);
        s_axis_dividend_tready = load_en;
        s_axis_divisor_tready  = load_en;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_reg        <= 5'd0;
            rem_reg        <= 33'd0;
            quo_reg        <= 32'd0;
            dsr_reg        <= 32'd0;
            dvd_reg        <= 32'd0;
            q_sign_reg     <= 1'b0;
            r_sign_reg     <= 1'b0;
            dz_reg         <= 1'b0;
            dout_reg       <= 64'd0;
            dout_valid_reg <= 1'b0;
        end else begin
            dout_valid_reg <= 1'b0;
            if (load_en) begin
                cnt_reg    <= 5'd0;
                rem_reg    <= 33'd0;
                quo_reg    <= dvd_mag;
                dsr_reg    <= dsr_mag;
                dvd_reg    <= s_axis_dividend_tdata;
                q_sign_reg <= dvd_neg ^ dsr_neg;
                r_sign_reg <= dvd_neg;
                dz_reg     <= (s_axis_divisor_tdata == 32'd0);
            end
            if (iter_en) begin
                rem_reg <= rem_next;
                quo_reg <= {quo_reg[30:0], q_bit};
                cnt_reg <= cnt_reg + 5'd1;
            end
            if (write_en) begin
                dout_reg       <= dz_reg ? {32'hFFFF_FFFF, dvd_reg} : {q_fix, r_fix};
                dout_valid_reg <= 1'b1;
            end
        end
    end

    assign m_axis_dout_tdata  = dout_reg;
    assign m_axis_dout_tvalid = dout_valid_reg;

endmodule

// File: tb/tb_axis_iter_div.sv
// Directed bench for axis_iter_div: an unsigned and a signed instance share the operand inputs.
module tb_axis_iter_div;

    logic        clk;
    logic        reset;
    logic [31:0] dividend, divisor;
    logic        dvd_valid, dsr_valid;
    logic        u_dvd_ready, u_dsr_ready, u_valid;
    logic        s_dvd_ready, s_dsr_ready, s_valid;
    logic [63:0] u_tdata, s_tdata;
    int          errors = 0;
    int          checks = 0;

    axis_iter_div #(.SIGNED(1'b0)) dut_u (
        .clk(clk), .reset(reset),
        .s_axis_dividend_tdata(dividend), .s_axis_dividend_tvalid(dvd_valid),
        .s_axis_dividend_tready(u_dvd_ready),
        .s_axis_divisor_tdata(divisor), .s_axis_divisor_tvalid(dsr_valid),
        .s_axis_divisor_tready(u_dsr_ready),
        .m_axis_dout_tdata(u_tdata), .m_axis_dout_tvalid(u_valid)
    );

    axis_iter_div #(.SIGNED(1'b1)) dut_s (
        .clk(clk), .reset(reset),
        .s_axis_dividend_tdata(dividend), .s_axis_dividend_tvalid(dvd_valid),
        .s_axis_dividend_tready(s_dvd_ready),
        .s_axis_divisor_tdata(divisor), .s_axis_divisor_tvalid(dsr_valid),
        .s_axis_divisor_tready(s_dsr_ready),
        .m_axis_dout_tdata(s_tdata), .m_axis_dout_tvalid(s_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One operation on both instances. Operands are scrambled but kept valid during CALC.
    task automatic test_divide(input string name, input logic [31:0] a, input logic [31:0] b,
                               input logic [63:0] exp_u, input logic [63:0] exp_s);
        logic [63:0] du, ds;
        int lat_u, lat_s, np_u, np_s;
        bit hs_ok;
        du = 64'd0; ds = 64'd0; lat_u = -1; lat_s = -1; np_u = 0; np_s = 0;
        @(negedge clk);
        dividend = a; divisor = b; dvd_valid = 1'b1; dsr_valid = 1'b1;
        #1;
        hs_ok = u_dvd_ready && u_dsr_ready && s_dvd_ready && s_dsr_ready;
        @(posedge clk); #1;
        dividend = ~a; divisor = b ^ 32'h0000_0005;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (u_valid) begin np_u++; lat_u = i; du = u_tdata; end
            if (s_valid) begin np_s++; lat_s = i; ds = s_tdata; end
            if (i <= 32 && (u_dvd_ready || u_dsr_ready || s_dvd_ready || s_dsr_ready)) hs_ok = 1'b0;
            if (i == 33) begin dvd_valid = 1'b0; dsr_valid = 1'b0; end
        end
        checks++;
        if (du !== exp_u) begin errors++; $display("FAIL %s unsigned tdata: got %h want %h", name, du, exp_u); end
        checks++;
        if (ds !== exp_s) begin errors++; $display("FAIL %s signed tdata: got %h want %h", name, ds, exp_s); end
        checks++;
        if (lat_u != 33 || lat_s != 33) begin
            errors++; $display("FAIL %s latency: got u=%0d s=%0d want 33", name, lat_u, lat_s);
        end
        checks++;
        if (np_u != 1 || np_s != 1) begin
            errors++; $display("FAIL %s pulse count: got u=%0d s=%0d want 1", name, np_u, np_s);
        end
        checks++;
        if (!hs_ok) begin errors++; $display("FAIL %s tready: got bad handshake want ready only in IDLE", name); end
        checks++;
        if (u_tdata !== exp_u || s_tdata !== exp_s) begin
            errors++; $display("FAIL %s data hold: got u=%h s=%h want u=%h s=%h", name, u_tdata, s_tdata, exp_u, exp_s);
        end
        $display("op %s: %h / %h -> u=%h s=%h lat=%0d/%0d", name, a, b, du, ds, lat_u, lat_s);
    endtask

    task automatic test_reset();
        reset = 1'b1; dividend = 32'd0; divisor = 32'd0; dvd_valid = 1'b0; dsr_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (u_valid !== 1'b0 || s_valid !== 1'b0) begin
            errors++; $display("FAIL reset tvalid: got u=%b s=%b want 0", u_valid, s_valid);
        end
        checks++;
        if (u_tdata !== 64'd0 || s_tdata !== 64'd0) begin
            errors++; $display("FAIL reset tdata: got u=%h s=%h want 0", u_tdata, s_tdata);
        end
        checks++;
        if (u_dvd_ready || u_dsr_ready || s_dvd_ready || s_dsr_ready) begin
            errors++; $display("FAIL reset tready: got high want 0");
        end
        @(negedge clk);
        reset = 1'b0;
        $display("reset: tvalid=%b/%b tdata=%h/%h", u_valid, s_valid, u_tdata, s_tdata);
    endtask

    task automatic test_unsigned();
        test_divide("u100div7", 32'd100, 32'd7, 64'h0000000E_00000002, 64'h0000000E_00000002);
    endtask

    task automatic test_signed();
        test_divide("m7div2", 32'hFFFF_FFF9, 32'd2, 64'h7FFFFFFC_00000001, 64'hFFFFFFFD_FFFFFFFF);
        test_divide("7divm2", 32'd7, 32'hFFFF_FFFE, 64'h00000000_00000007, 64'hFFFFFFFD_00000001);
    endtask

    task automatic test_overflow();
        test_divide("ovf", 32'h8000_0000, 32'hFFFF_FFFF, 64'h00000000_80000000, 64'h80000000_00000000);
        test_divide("fullrange", 32'hFFFF_FFFF, 32'd1, 64'hFFFFFFFF_00000000, 64'hFFFFFFFF_00000000);
    endtask

    task automatic test_div_zero();
        test_divide("divzero", 32'hFFFF_FFF6, 32'd0, 64'hFFFFFFFF_FFFFFFF6, 64'hFFFFFFFF_FFFFFFF6);
    endtask

    task automatic test_lone_valid();
        int np;
        bit rdy;
        np = 0; rdy = 1'b0;
        @(negedge clk);
        dividend = 32'd40; divisor = 32'd8; dvd_valid = 1'b1; dsr_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            if (u_dvd_ready || u_dsr_ready || s_dvd_ready || s_dsr_ready) rdy = 1'b1;
            @(negedge clk);
        end
        dvd_valid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (u_valid || s_valid) np++;
        end
        checks++;
        if (rdy) begin errors++; $display("FAIL lone_valid tready: got high want 0"); end
        checks++;
        if (np != 0) begin errors++; $display("FAIL lone_valid pulses: got %0d want 0", np); end
        $display("lone_valid: ready_seen=%b pulses=%0d", rdy, np);
    endtask

    task automatic test_back_to_back();
        int first, second, np;
        first = -1; second = -1; np = 0;
        @(negedge clk);
        dividend = 32'd12; divisor = 32'd4; dvd_valid = 1'b1; dsr_valid = 1'b1;
        @(posedge clk); #1;
        for (int i = 1; i <= 75; i++) begin
            @(posedge clk); #1;
            if (u_valid && s_valid) begin
                np++;
                if (first < 0) first = i; else if (second < 0) second = i;
            end
            if (i == 67) begin dvd_valid = 1'b0; dsr_valid = 1'b0; end
        end
        checks++;
        if (first != 33 || second != 67) begin
            errors++; $display("FAIL b2b timing: got %0d,%0d want 33,67", first, second);
        end
        checks++;
        if (np != 2) begin errors++; $display("FAIL b2b pulse count: got %0d want 2", np); end
        checks++;
        if (u_tdata !== 64'h00000003_00000000 || s_tdata !== 64'h00000003_00000000) begin
            errors++; $display("FAIL b2b tdata: got u=%h s=%h want 0000000300000000", u_tdata, s_tdata);
        end
        $display("back_to_back: pulses at %0d,%0d count=%0d", first, second, np);
    endtask

    task automatic test_reset_mid();
        int np;
        np = 0;
        @(negedge clk);
        dividend = 32'd50; divisor = 32'd5; dvd_valid = 1'b1; dsr_valid = 1'b1;
        @(posedge clk); #1;
        dvd_valid = 1'b0; dsr_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        checks++;
        if (u_valid !== 1'b0 || s_valid !== 1'b0) begin
            errors++; $display("FAIL reset_mid tvalid: got u=%b s=%b want 0", u_valid, s_valid);
        end
        checks++;
        if (u_tdata !== 64'd0 || s_tdata !== 64'd0) begin
            errors++; $display("FAIL reset_mid tdata: got u=%h s=%h want 0", u_tdata, s_tdata);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (u_valid || s_valid) np++;
        end
        checks++;
        if (np != 0) begin errors++; $display("FAIL reset_mid stray pulse: got %0d want 0", np); end
        $display("reset_mid: tdata cleared, stray pulses=%0d", np);
        test_divide("post_reset", 32'd9, 32'd3, 64'h00000003_00000000, 64'h00000003_00000000);
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_overflow();
        test_div_zero();
        test_lone_valid();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
